// File: rtl/sc_lane_scheduler.sv
// sc_lane_scheduler: round-robin obstacle-lane rotator with frame-synchronous shadow commit and collision flag
module sc_lane_scheduler #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int LANES = 6,
  parameter int LEVEL_DATAWIDTH = 3,
  parameter int PRESCALER_DATAWIDTH = 23,
  parameter int TICK_PRESCALE = 2500000,
  parameter logic [DATAWIDTH_BUS*LANES-1:0] SEED_PATTERNS = 48'hC3_88_33_E0_18_C0
) (
  input  logic                               SC_LANE_SCHEDULER_CLOCK_50,
  input  logic                               SC_LANE_SCHEDULER_RESET_InLow,
  input  logic                               SC_LANE_SCHEDULER_Enable_InHigh,
  input  logic                               SC_LANE_SCHEDULER_Load_InHigh,
  input  logic [LEVEL_DATAWIDTH-1:0]         SC_LANE_SCHEDULER_Level_InBus,
  input  logic                               SC_LANE_SCHEDULER_FrameSync_InHigh,
  input  logic [2:0]                         SC_LANE_SCHEDULER_FrogRow_InBus,
  input  logic [2:0]                         SC_LANE_SCHEDULER_FrogCol_InBus,
  output logic [DATAWIDTH_BUS*LANES-1:0]     SC_LANE_SCHEDULER_Lanes_OutBus,
  output logic                               SC_LANE_SCHEDULER_Updated_OutHigh,
  output logic                               SC_LANE_SCHEDULER_Busy_OutHigh,
  output logic                               SC_LANE_SCHEDULER_Hit_OutHigh
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [LANES-1:0][3:0] BASE = {4'd3, 4'd6, 4'd4, 4'd7, 4'd5, 4'd8};
  function automatic logic [3:0] period(input logic [3:0] b, input logic [LEVEL_DATAWIDTH-1:0] lv);
    return (b > 4'(lv)) ? b - 4'(lv) : 4'd1;
  endfunction
  logic [LANES-1:0][DATAWIDTH_BUS-1:0] w_q, w_d, s_q, s_d;
  logic [LANES-1:0][3:0] c_q, c_d;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic pend_q, pend_d, upd_q, upd_d, hit_q, hit_d;
  logic [PRESCALER_DATAWIDTH-1:0] presc_q, presc_d;
  logic tick, commit;
  logic [DATAWIDTH_BUS-1:0] cur;
  logic [2:0] hl, hb;
  always_comb begin
    tick = SC_LANE_SCHEDULER_Enable_InHigh && presc_q == PRESCALER_DATAWIDTH'(TICK_PRESCALE - 1);
    commit = SC_LANE_SCHEDULER_FrameSync_InHigh && pend_q && state_q != SCAN;
    presc_d = tick ? '0 : SC_LANE_SCHEDULER_Enable_InHigh ? presc_q + PRESCALER_DATAWIDTH'(1) : presc_q;
    w_d = w_q;
    c_d = c_q;
    s_d = commit ? w_q : s_q;
    pend_d = pend_q & ~commit;
    upd_d = commit;
    state_d = state_q;
    idx_d = idx_q;
    cur = w_q[idx_q];
    hl = SC_LANE_SCHEDULER_FrogRow_InBus - 3'd1;
    hb = 3'(DATAWIDTH_BUS - 1) - SC_LANE_SCHEDULER_FrogCol_InBus;
    hit_d = SC_LANE_SCHEDULER_FrogRow_InBus != 3'd0 && SC_LANE_SCHEDULER_FrogRow_InBus <= 3'(LANES) && s_q[hl][hb];
    case (state_q)
      IDLE: begin
        state_d = tick ? SCAN : IDLE;
        idx_d = '0;
      end
      SCAN: begin
        if (c_q[idx_q] == 4'd1) begin
          w_d[idx_q] = idx_q[0] ? {cur[0], cur[DATAWIDTH_BUS-1:1]} : {cur[DATAWIDTH_BUS-2:0], cur[DATAWIDTH_BUS-1]};
          c_d[idx_q] = period(BASE[idx_q], SC_LANE_SCHEDULER_Level_InBus);
        end else begin
          c_d[idx_q] = c_q[idx_q] - 4'd1;
        end
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'(LANES - 1) ? DONE : SCAN;
      end
      DONE: begin
        pend_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (SC_LANE_SCHEDULER_Load_InHigh) begin
      w_d = SEED_PATTERNS;
      s_d = SEED_PATTERNS;
      for (int k = 0; k < LANES; k++) c_d[k] = period(BASE[k], SC_LANE_SCHEDULER_Level_InBus);
      pend_d = 1'b0;
      upd_d = 1'b0;
      state_d = IDLE;
      idx_d = '0;
      presc_d = '0;
    end
  end
  always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50 or negedge SC_LANE_SCHEDULER_RESET_InLow) begin
    if (!SC_LANE_SCHEDULER_RESET_InLow) begin
      w_q <= SEED_PATTERNS;
      s_q <= SEED_PATTERNS;
      c_q <= BASE;
      state_q <= IDLE;
      idx_q <= '0;
      pend_q <= 1'b0;
      upd_q <= 1'b0;
      hit_q <= 1'b0;
      presc_q <= '0;
    end else begin
      w_q <= w_d;
      s_q <= s_d;
      c_q <= c_d;
      state_q <= state_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      upd_q <= upd_d;
      hit_q <= hit_d;
      presc_q <= presc_d;
    end
  end
  assign SC_LANE_SCHEDULER_Lanes_OutBus = s_q;
  assign SC_LANE_SCHEDULER_Updated_OutHigh = upd_q;
  assign SC_LANE_SCHEDULER_Busy_OutHigh = state_q == SCAN;
  assign SC_LANE_SCHEDULER_Hit_OutHigh = hit_q;
endmodule

// File: tb/tb_sc_lane_scheduler.sv
// tb_sc_lane_scheduler: scoreboard bench with a scan-at-once behavioural model of the lane scheduler
module tb_sc_lane_scheduler;
  localparam int TP = 16;
  localparam logic [47:0] SEED = 48'hC3_88_33_E0_18_C0;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, fs = 1'b0;
  logic [2:0] lvl = 3'd0, row = 3'd0, col = 3'd0;
  logic [47:0] lanes;
  logic upd, busy, hit;
  int tests = 0, fails = 0;
  int m_w[6], m_s[6], m_c[6];
  int m_cnt, m_since, m_pend, m_hit;
  int base_t[6] = '{8, 5, 7, 4, 6, 3};
  logic [47:0] q[$];
  bit mon_on = 1'b0;
  always #5 clk = ~clk;
  sc_lane_scheduler #(.TICK_PRESCALE(TP)) dut (
    .SC_LANE_SCHEDULER_CLOCK_50(clk),
    .SC_LANE_SCHEDULER_RESET_InLow(rst_n),
    .SC_LANE_SCHEDULER_Enable_InHigh(en),
    .SC_LANE_SCHEDULER_Load_InHigh(load),
    .SC_LANE_SCHEDULER_Level_InBus(lvl),
    .SC_LANE_SCHEDULER_FrameSync_InHigh(fs),
    .SC_LANE_SCHEDULER_FrogRow_InBus(row),
    .SC_LANE_SCHEDULER_FrogCol_InBus(col),
    .SC_LANE_SCHEDULER_Lanes_OutBus(lanes),
    .SC_LANE_SCHEDULER_Updated_OutHigh(upd),
    .SC_LANE_SCHEDULER_Busy_OutHigh(busy),
    .SC_LANE_SCHEDULER_Hit_OutHigh(hit)
  );
  task automatic chk(input string n, input logic [47:0] a, input logic [47:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic int per(input int k, input int lv);
    return (base_t[k] - lv < 1) ? 1 : base_t[k] - lv;
  endfunction
  function automatic logic [47:0] s_bus();
    logic [47:0] r;
    for (int k = 0; k < 6; k++) r[8*k +: 8] = 8'(m_s[k]);
    return r;
  endfunction
  task automatic seed_lanes();
    logic [47:0] sd;
    sd = SEED;
    for (int k = 0; k < 6; k++) begin
      m_w[k] = int'(sd[8*k +: 8]);
      m_s[k] = m_w[k];
    end
    m_cnt = 0;
    m_since = -1;
    m_pend = 0;
  endtask
  task automatic model_step();
    bit tk;
    int hn, r;
    r = int'(row);
    hn = (r >= 1 && r <= 6) ? (m_s[(r >= 1) ? r - 1 : 0] >> (7 - int'(col))) & 1 : 0;
    tk = en && m_cnt == TP - 1;
    if (load) begin
      seed_lanes();
      for (int k = 0; k < 6; k++) m_c[k] = per(k, int'(lvl));
    end else begin
      if (fs && m_pend == 1 && !(m_since >= 1 && m_since <= 6)) begin
        for (int k = 0; k < 6; k++) m_s[k] = m_w[k];
        m_pend = 0;
        q.push_back(s_bus());
      end
      if (m_since == 7) begin
        m_pend = 1;
        m_since = -1;
      end else if (m_since >= 0) begin
        m_since++;
      end else if (tk) begin
        for (int k = 0; k < 6; k++) begin
          if (m_c[k] == 1) begin
            m_w[k] = (k % 2 == 0) ? ((m_w[k] << 1) | (m_w[k] >> 7)) & 255 : (m_w[k] >> 1) | ((m_w[k] & 1) << 7);
            m_c[k] = per(k, int'(lvl));
          end else begin
            m_c[k]--;
          end
        end
        m_since = 1;
      end
      if (en) m_cnt = tk ? 0 : m_cnt + 1;
    end
    m_hit = hn;
  endtask
  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
  end
  always @(negedge clk) if (mon_on) begin
    chk("busy", 48'(busy), 48'(m_since >= 1 && m_since <= 6));
    chk("hit", 48'(hit), 48'(m_hit));
    chk("lanes", lanes, s_bus());
    if (upd || q.size() > 0) begin
      if (!upd) begin
        chk("updated_missing", 48'(upd), 48'd1);
        void'(q.pop_front());
      end else if (q.size() == 0) begin
        chk("updated_unexpected", 48'(upd), 48'd0);
      end else begin
        chk("commit", lanes, q.pop_front());
      end
    end
  end
  task automatic wait_busy(input logic v, input int lim);
    int i;
    i = 0;
    while (busy !== v && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("busy_wait", 48'(busy), 48'(v));
  endtask
  task automatic pulse_fs();
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
  endtask
  task automatic scan_commit();
    wait_busy(1'b1, 40);
    wait_busy(1'b0, 20);
    pulse_fs();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    seed_lanes();
    for (int k = 0; k < 6; k++) m_c[k] = base_t[k];
    m_hit = 0;
    repeat (3) @(negedge clk);
    chk("reset_lanes", lanes, SEED);
    chk("reset_busy", 48'(busy), 48'd0);
    chk("reset_updated", 48'(upd), 48'd0);
    chk("reset_hit", 48'(hit), 48'd0);
    rst_n = 1'b1;
    mon_on = 1'b1;
    row = 3'd1;
    col = 3'd0;
    @(negedge clk);
    chk("hit_row1_col0", 48'(hit), 48'd1);
    col = 3'd2;
    @(negedge clk);
    chk("hit_row1_col2", 48'(hit), 48'd0);
    row = 3'd0;
    col = 3'($urandom_range(7));
    @(negedge clk);
    chk("hit_row0", 48'(hit), 48'd0);
    en = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      scan_commit();
      if (n == 3) chk("lvl0_tick3", lanes, 48'hE1_88_33_E0_18_C0);
      if (n == 4) chk("lvl0_tick4", lanes, 48'hE1_88_99_E0_18_C0);
    end
    for (int n = 0; n < 3; n++) begin
      wait_busy(1'b1, 40);
      wait_busy(1'b0, 20);
    end
    wait_busy(1'b1, 40);
    pulse_fs();
    chk("fs_while_busy", 48'(upd), 48'd0);
    wait_busy(1'b0, 20);
    pulse_fs();
    chk("fs_after_busy", 48'(upd), 48'd1);
    lvl = 3'd5;
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    scan_commit();
    chk("lvl5_first", lanes, 48'hE1_11_99_E0_0C_C0);
    for (int n = 0; n < 5; n++) scan_commit();
    wait_busy(1'b1, 40);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("load_busy", 48'(busy), 48'd0);
    chk("load_lanes", lanes, SEED);
    pulse_fs();
    chk("load_no_update", 48'(upd), 48'd0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      fs = ($urandom_range(5) == 0);
      en = ($urandom_range(9) != 0);
      load = ($urandom_range(399) == 0);
      row = 3'($urandom_range(7));
      col = 3'($urandom_range(7));
      if (m_since < 0 && m_cnt < TP - 4 && $urandom_range(49) == 0) lvl = 3'($urandom_range(7));
    end
    @(negedge clk);
    fs = 1'b0;
    en = 1'b0;
    load = 1'b0;
    repeat (12) @(negedge clk);
    chk("queue_drained", 48'(q.size()), 48'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
